// File: rtl/crd_rd_arb_pkg.sv
// crd_rd_arb_pkg: shared sizing and requester IDs for the coordinate-read arbiter
package crd_rd_arb_pkg;
  localparam int NUM_REQ    = 2;
  localparam int MAX_OUTSTD = 4;
  localparam int REQ_KNN    = 0;
  localparam int REQ_FPS    = 1;
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
endpackage

// File: rtl/arb_id_fifo.sv
// arb_id_fifo: first-word fall-through FIFO of granted requester IDs with sync clear
module arb_id_fifo #(
  parameter int DW    = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [DW-1:0]          din_i,
  input  logic                   pop_i,
  output logic [DW-1:0]          dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] cnt_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr, rd;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign dout_o  = mem_q[rp_q];
  assign cnt_o   = cnt_q;
  assign wr      = push_i && !full_o && !clr_i;
  assign rd      = pop_i && !empty_o && !clr_i;
  // pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wp_d  = clr_i ? '0 : wp_q + AW'(wr);
    rp_d  = clr_i ? '0 : rp_q + AW'(rd);
    cnt_d = clr_i ? '0 : cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (wr) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/crd_rd_arb.sv
// crd_rd_arb: round-robin arbiter of requester coordinate reads onto one GLB port,
// routing in-order read data back to the requester that issued each address
module crd_rd_arb
  import crd_rd_arb_pkg::*;
#(
  parameter int NUM_REQ    = crd_rd_arb_pkg::NUM_REQ,
  parameter int IDX_WIDTH  = 10,
  parameter int SRAM_WIDTH = 256,
  parameter int MAX_OUTSTD = crd_rd_arb_pkg::MAX_OUTSTD
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         CCUARB_Rst,
  input  logic [NUM_REQ*IDX_WIDTH-1:0] REQARB_Addr,
  input  logic [NUM_REQ-1:0]           REQARB_AddrVld,
  output logic [NUM_REQ-1:0]           ARBREQ_AddrRdy,
  output logic [SRAM_WIDTH-1:0]        ARBREQ_Dat,
  output logic [NUM_REQ-1:0]           ARBREQ_DatVld,
  input  logic [NUM_REQ-1:0]           REQARB_DatRdy,
  output logic [IDX_WIDTH-1:0]         ARBGLB_CrdAddr,
  output logic                         ARBGLB_CrdAddrVld,
  input  logic                         GLBARB_CrdAddrRdy,
  input  logic [SRAM_WIDTH-1:0]        GLBARB_Crd,
  input  logic                         GLBARB_CrdVld,
  output logic                         ARBGLB_CrdRdy,
  output logic [$clog2(MAX_OUTSTD):0]  ARB_Outstd,
  output logic                         ARB_Err
);
  localparam int IDW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [IDW-1:0] rr_q, rr_d, lid_q, lid_d, win, sel, head;
  logic           lock_q, lock_d, err_q, err_d, found, credit, ahs, dhs, full, empty;
  int             j;
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j -= NUM_REQ;
      if (!found && REQARB_AddrVld[j]) begin
        win   = IDW'(j);
        found = 1'b1;
      end
    end
  end
  // a presented-but-unaccepted grant is held so the GLB sees a stable address
  assign sel               = lock_q ? lid_q : win;
  assign credit            = rst_n && !full;
  assign ARBGLB_CrdAddrVld = (found || lock_q) && credit;
  assign ARBGLB_CrdAddr    = REQARB_Addr[sel*IDX_WIDTH +: IDX_WIDTH];
  assign ARBREQ_AddrRdy    = NUM_REQ'(GLBARB_CrdAddrRdy && credit) << sel;
  assign ahs               = ARBGLB_CrdAddrVld && GLBARB_CrdAddrRdy;
  assign ARBREQ_DatVld     = NUM_REQ'(GLBARB_CrdVld && !empty) << head;
  assign ARBGLB_CrdRdy     = !empty && REQARB_DatRdy[head];
  assign dhs               = GLBARB_CrdVld && ARBGLB_CrdRdy;
  assign ARBREQ_Dat        = GLBARB_Crd;
  assign ARB_Err           = err_q;
  always_comb begin
    rr_d   = CCUARB_Rst ? IDW'(REQ_KNN) : ahs ? IDW'((int'(sel) + 1) % NUM_REQ) : rr_q;
    lock_d = !CCUARB_Rst && ARBGLB_CrdAddrVld && !GLBARB_CrdAddrRdy;
    lid_d  = sel;
    err_d  = !CCUARB_Rst && (err_q || (GLBARB_CrdVld && empty));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q   <= IDW'(REQ_KNN);
      lid_q  <= '0;
      lock_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      lid_q  <= lid_d;
      lock_q <= lock_d;
      err_q  <= err_d;
    end
  end
  arb_id_fifo #(.DW(IDW), .DEPTH(MAX_OUTSTD)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (CCUARB_Rst),
    .push_i  (ahs),
    .din_i   (sel),
    .pop_i   (dhs),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .cnt_o   (ARB_Outstd)
  );
endmodule

// File: tb/tb_crd_rd_arb.sv
// tb_crd_rd_arb: directed scenarios plus randomized traffic against a queue-based model
module tb_crd_rd_arb;
  localparam int NR = 2, IW = 10, SW = 256, MO = 4;
  logic clk = 0, rst_n = 1, ccu = 0;
  logic [NR*IW-1:0] addr = '0;
  logic [NR-1:0] avld = '0, drdy = '0, ardy, dvld;
  logic [SW-1:0] crd = '0, dat;
  logic [IW-1:0] gaddr;
  logic grdy = 0, cvld = 0, gavld, crdy, err;
  logic [2:0] outstd;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  crd_rd_arb #(.NUM_REQ(NR), .IDX_WIDTH(IW), .SRAM_WIDTH(SW), .MAX_OUTSTD(MO)) dut (
    .clk(clk), .rst_n(rst_n), .CCUARB_Rst(ccu),
    .REQARB_Addr(addr), .REQARB_AddrVld(avld), .ARBREQ_AddrRdy(ardy),
    .ARBREQ_Dat(dat), .ARBREQ_DatVld(dvld), .REQARB_DatRdy(drdy),
    .ARBGLB_CrdAddr(gaddr), .ARBGLB_CrdAddrVld(gavld), .GLBARB_CrdAddrRdy(grdy),
    .GLBARB_Crd(crd), .GLBARB_CrdVld(cvld), .ARBGLB_CrdRdy(crdy),
    .ARB_Outstd(outstd), .ARB_Err(err)
  );

  task automatic tick; @(posedge clk); #1; endtask
  task automatic idle; avld = '0; drdy = '0; grdy = 0; cvld = 0; ccu = 0; endtask
  task automatic clear; idle(); ccu = 1; tick(); ccu = 0; endtask

  task automatic test_reset;
    #2 rst_n = 0;
    avld = '1; grdy = 1; cvld = 1; drdy = '1; addr = {10'd9, 10'd5};
    #1;
    n_vec++; if (ardy !== '0) begin n_err++; $display("FAIL rst_ardy got %b want 00", ardy); end
    n_vec++; if (gavld !== 1'b0) begin n_err++; $display("FAIL rst_gavld got %b want 0", gavld); end
    n_vec++; if (dvld !== '0) begin n_err++; $display("FAIL rst_dvld got %b want 00", dvld); end
    n_vec++; if (crdy !== 1'b0) begin n_err++; $display("FAIL rst_crdy got %b want 0", crdy); end
    n_vec++; if (outstd !== 3'd0) begin n_err++; $display("FAIL rst_outstd got %0d want 0", outstd); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", err); end
    idle(); tick(); rst_n = 1; tick();
  endtask

  task automatic test_alternate;
    int e;
    clear(); addr = {10'd9, 10'd5}; avld = 2'b11; grdy = 1;
    for (int i = 0; i < 4; i++) begin
      e = i % 2; #1;
      n_vec++; if (gavld !== 1'b1) begin n_err++; $display("FAIL alt_gavld[%0d] got %b want 1", i, gavld); end
      n_vec++; if (gaddr !== ((e == 1) ? 10'd9 : 10'd5)) begin n_err++; $display("FAIL alt_addr[%0d] got %0d want %0d", i, gaddr, (e == 1) ? 9 : 5); end
      n_vec++; if (ardy !== NR'(1 << e)) begin n_err++; $display("FAIL alt_ardy[%0d] got %b want %b", i, ardy, NR'(1 << e)); end
      tick();
    end
    #1;
    n_vec++; if (outstd !== 3'd4) begin n_err++; $display("FAIL alt_full got %0d want 4", outstd); end
    n_vec++; if (gavld !== 1'b0) begin n_err++; $display("FAIL alt_nocredit got %b want 0", gavld); end
    avld = '0; cvld = 1; drdy = 2'b11;
    for (int i = 0; i < 4; i++) begin
      e = i % 2; crd = {8{$urandom()}}; #1;
      n_vec++; if (dvld !== NR'(1 << e)) begin n_err++; $display("FAIL alt_dvld[%0d] got %b want %b", i, dvld, NR'(1 << e)); end
      n_vec++; if (dat !== crd) begin n_err++; $display("FAIL alt_dat[%0d] got %h want %h", i, dat, crd); end
      n_vec++; if (crdy !== 1'b1) begin n_err++; $display("FAIL alt_crdy[%0d] got %b want 1", i, crdy); end
      tick();
    end
    cvld = 0; #1;
    n_vec++; if (outstd !== 3'd0) begin n_err++; $display("FAIL alt_drain got %0d want 0", outstd); end
  endtask

  task automatic test_lock;
    clear(); addr = {10'd9, 10'd5}; avld = 2'b01; grdy = 1; tick();
    grdy = 0; #1;
    n_vec++; if (gaddr !== 10'd5 || gavld !== 1'b1 || ardy !== 2'b00) begin n_err++; $display("FAIL lock_c0 got addr=%0d vld=%b rdy=%b want 5 1 00", gaddr, gavld, ardy); end
    tick(); avld = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if (gaddr !== 10'd5 || ardy !== 2'b00) begin n_err++; $display("FAIL lock_hold[%0d] got addr=%0d rdy=%b want 5 00", i, gaddr, ardy); end
      tick();
    end
    grdy = 1; #1;
    n_vec++; if (gaddr !== 10'd5 || ardy !== 2'b01) begin n_err++; $display("FAIL lock_hs got addr=%0d rdy=%b want 5 01", gaddr, ardy); end
    tick(); #1;
    n_vec++; if (gaddr !== 10'd9 || ardy !== 2'b10) begin n_err++; $display("FAIL lock_after got addr=%0d rdy=%b want 9 10", gaddr, ardy); end
    tick(); #1;
    n_vec++; if (outstd !== 3'd3) begin n_err++; $display("FAIL lock_outstd got %0d want 3", outstd); end
  endtask

  task automatic test_full;
    int acc = 0;
    clear(); addr = {10'd9, 10'd5}; avld = 2'b01; grdy = 1;
    for (int i = 0; i < 5; i++) begin
      #1; if (gavld && ardy[0]) acc++;
      n_vec++; if (gavld !== (i < 4)) begin n_err++; $display("FAIL full_gavld[%0d] got %b want %b", i, gavld, i < 4); end
      tick();
    end
    #1;
    n_vec++; if (acc != 4) begin n_err++; $display("FAIL full_accepted got %0d want 4", acc); end
    n_vec++; if (outstd !== 3'd4 || ardy !== 2'b00) begin n_err++; $display("FAIL full_state got outstd=%0d rdy=%b want 4 00", outstd, ardy); end
    cvld = 1; drdy = 2'b01; #1;
    n_vec++; if (gavld !== 1'b0 || crdy !== 1'b1 || dvld !== 2'b01) begin n_err++; $display("FAIL full_pop got vld=%b crdy=%b dvld=%b want 0 1 01", gavld, crdy, dvld); end
    tick(); cvld = 0; #1;
    n_vec++; if (outstd !== 3'd3 || gavld !== 1'b1) begin n_err++; $display("FAIL full_after got outstd=%0d vld=%b want 3 1", outstd, gavld); end
  endtask

  task automatic test_backpressure;
    clear(); grdy = 1; avld = 2'b10; tick(); avld = 2'b01; tick();
    avld = '0; grdy = 0; cvld = 1; drdy = 2'b01;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if (dvld !== 2'b10 || crdy !== 1'b0 || outstd !== 3'd2) begin n_err++; $display("FAIL bp_hold[%0d] got dvld=%b crdy=%b outstd=%0d want 10 0 2", i, dvld, crdy, outstd); end
      tick();
    end
    drdy = 2'b11; #1;
    n_vec++; if (dvld !== 2'b10 || crdy !== 1'b1) begin n_err++; $display("FAIL bp_rel got dvld=%b crdy=%b want 10 1", dvld, crdy); end
    tick(); #1;
    n_vec++; if (dvld !== 2'b01) begin n_err++; $display("FAIL bp_second got dvld=%b want 01", dvld); end
    tick(); cvld = 0; #1;
    n_vec++; if (outstd !== 3'd0) begin n_err++; $display("FAIL bp_drain got %0d want 0", outstd); end
  endtask

  task automatic test_err;
    clear(); cvld = 1; drdy = '1; #1;
    n_vec++; if (crdy !== 1'b0 || dvld !== 2'b00 || err !== 1'b0) begin n_err++; $display("FAIL err_pulse got crdy=%b dvld=%b err=%b want 0 00 0", crdy, dvld, err); end
    tick(); cvld = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky[%0d] got %b want 1", i, err); end
      tick();
    end
    ccu = 1; tick(); ccu = 0; #1;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clear got %b want 0", err); end
    grdy = 1; avld = 2'b01; tick(); tick(); idle();
    rst_n = 0; #1;
    n_vec++; if (outstd !== 3'd0) begin n_err++; $display("FAIL err_rstmid got %0d want 0", outstd); end
    tick(); rst_n = 1; cvld = 1; drdy = '1; #1;
    n_vec++; if (dvld !== 2'b00 || crdy !== 1'b0) begin n_err++; $display("FAIL err_stale got dvld=%b crdy=%b want 00 0", dvld, crdy); end
    tick(); cvld = 0; #1;
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_stale_flag got %b want 1", err); end
  endtask

  task automatic test_clear;
    clear(); addr = {10'd9, 10'd5}; avld = 2'b11; grdy = 1;
    tick(); tick(); tick(); #1;
    n_vec++; if (outstd !== 3'd3) begin n_err++; $display("FAIL clr_pre got %0d want 3", outstd); end
    ccu = 1; tick(); ccu = 0; #1;
    n_vec++; if (outstd !== 3'd0) begin n_err++; $display("FAIL clr_outstd got %0d want 0", outstd); end
    n_vec++; if (gaddr !== 10'd5 || ardy !== 2'b01) begin n_err++; $display("FAIL clr_grant got addr=%0d rdy=%b want 5 01", gaddr, ardy); end
    idle();
  endtask

  task automatic test_random;
    int q[$];
    int ptr = 0, lid = 0, w, h, j;
    bit lock = 0, merr = 0, any, credit, nonempty, e_gavld, e_crdy;
    logic [NR-1:0] e_ardy, e_dvld;
    clear();
    for (int c = 0; c < 3000; c++) begin
      avld = NR'($urandom()); grdy = $urandom_range(0, 3) != 0; cvld = $urandom_range(0, 1) == 1;
      drdy = NR'($urandom()); addr = (NR*IW)'($urandom()); crd = {8{$urandom()}};
      ccu = $urandom_range(0, 99) == 0;
      credit = q.size() < MO;
      if (lock) begin w = lid; any = 1; end
      else begin
        any = 0; w = ptr;
        for (int k = 0; k < NR; k++) begin
          j = (ptr + k) % NR;
          if (!any && avld[j]) begin w = j; any = 1; end
        end
      end
      e_gavld = any && credit;
      e_ardy = (credit && grdy) ? NR'(1 << w) : '0;
      nonempty = q.size() > 0;
      h = nonempty ? q[0] : 0;
      e_dvld = (nonempty && cvld) ? NR'(1 << h) : '0;
      e_crdy = nonempty && drdy[h];
      #1;
      n_vec++; if (gavld !== e_gavld) begin n_err++; $display("FAIL rnd_gavld@%0d got %b want %b", c, gavld, e_gavld); end
      if (any) begin
        n_vec++; if (gaddr !== addr[w*IW +: IW]) begin n_err++; $display("FAIL rnd_addr@%0d got %0d want %0d", c, gaddr, addr[w*IW +: IW]); end
        n_vec++; if (ardy !== e_ardy) begin n_err++; $display("FAIL rnd_ardy@%0d got %b want %b", c, ardy, e_ardy); end
      end
      n_vec++; if (dvld !== e_dvld) begin n_err++; $display("FAIL rnd_dvld@%0d got %b want %b", c, dvld, e_dvld); end
      n_vec++; if (crdy !== e_crdy) begin n_err++; $display("FAIL rnd_crdy@%0d got %b want %b", c, crdy, e_crdy); end
      n_vec++; if (int'(outstd) != q.size()) begin n_err++; $display("FAIL rnd_outstd@%0d got %0d want %0d", c, outstd, q.size()); end
      n_vec++; if (err !== merr) begin n_err++; $display("FAIL rnd_err@%0d got %b want %b", c, err, merr); end
      n_vec++; if (dat !== crd) begin n_err++; $display("FAIL rnd_dat@%0d got %h want %h", c, dat, crd); end
      if (ccu) begin
        q.delete(); ptr = 0; lock = 0; merr = 0;
      end else begin
        if (cvld && !nonempty) merr = 1;
        if (cvld && e_crdy) void'(q.pop_front());
        if (e_gavld && grdy) begin q.push_back(w); ptr = (w + 1) % NR; end
        lock = e_gavld && !grdy;
        lid = w;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_lock();
    test_full();
    test_backpressure();
    test_err();
    test_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
